// File: rtl/trng_sched.sv
// rtl/trng_sched.sv - TRNG sampling scheduler with warmup, word packing and repetition health test
//
// Purpose: samples a raw TRNG byte stream every SAMPLE_DIV cycles, throws away
// the first WARMUP_SAMPLES samples after enable, packs the next four samples
// into a 32-bit word (first sample in the low byte) and presents it with a
// valid/ready handshake. Every sample taken while active also feeds a
// repetition-count health test. REP_LIMIT identical samples in a row latch a
// sticky failure that only rst clears.
//
// Ports:
//   clk         - system clock, rising edge
//   rst         - synchronous active-high reset
//   en          - level enable for sampling
//   rnddata     - raw byte from the TRNG core
//   out_ready   - consumer ready
//   out_valid   - packed word available
//   out_data    - packed random word
//   health_fail - sticky health-test failure
//   busy        - high in every state except IDLE and FAIL

module trng_sched #(
    parameter int SAMPLE_DIV     = 500,
    parameter int WARMUP_SAMPLES = 64,
    parameter int REP_LIMIT      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  rnddata,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        health_fail,
    output logic        busy
);

    localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam int WU_W  = $clog2(WARMUP_SAMPLES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [WU_W-1:0]  WU_LAST  = WU_W'(WARMUP_SAMPLES - 1);
    localparam logic [3:0]       REP_MAX  = 4'(REP_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_COLLECT,
        S_PRESENT,
        S_FAIL
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] div_cnt;
    logic [WU_W-1:0]  wu_cnt;
    logic [1:0]       byte_idx;
    logic [3:0]       rep_cnt;
    logic [7:0]       prev_sample;

    logic       active;
    logic       strobe;
    logic [3:0] rep_next;
    logic       rep_hit;
    logic       handshake;
    logic       pack_write;

    assign active    = (state == S_WARMUP) || (state == S_COLLECT) || (state == S_PRESENT);
    assign strobe    = active && (div_cnt == DIV_LAST);
    assign handshake = (state == S_PRESENT) && out_ready;

    // rep_cnt == 0 marks "no previous sample since enable", so the first
    // sample always restarts the run at 1 even if it happens to equal 0.
    // rep_cnt never exceeds REP_LIMIT (<= 15), so the increment cannot wrap.
    assign rep_next = ((rep_cnt != 4'd0) && (rnddata == prev_sample)) ? rep_cnt + 4'd1 : 4'd1;
    assign rep_hit  = strobe && (rep_next >= REP_MAX);

    // A sample is packed only when it is not being lost to a failure or a
    // disable in the same cycle; out_data is otherwise untouched.
    assign pack_write = (state == S_COLLECT) && strobe && en && !rep_hit;

    assign out_valid   = (state == S_PRESENT);
    assign health_fail = (state == S_FAIL);
    assign busy        = active;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (en) begin
                    state_next = S_WARMUP;
                end
            end
            S_WARMUP, S_COLLECT, S_PRESENT: begin
                // Failure wins over disable, handshake and any state advance.
                if (rep_hit) begin
                    state_next = S_FAIL;
                end else if (!en) begin
                    state_next = S_IDLE;
                end else begin
                    case (state)
                        S_WARMUP: begin
                            if (strobe && (wu_cnt == WU_LAST)) begin
                                state_next = S_COLLECT;
                            end
                        end
                        S_COLLECT: begin
                            if (strobe && (byte_idx == 2'd3)) begin
                                state_next = S_PRESENT;
                            end
                        end
                        default: begin
                            if (handshake) begin
                                state_next = S_COLLECT;
                            end
                        end
                    endcase
                end
            end
            S_FAIL: begin
                state_next = S_FAIL;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            wu_cnt      <= '0;
            byte_idx    <= 2'd0;
            rep_cnt     <= 4'd0;
            prev_sample <= 8'd0;
            out_data    <= 32'd0;
        end else begin
            // Divider: held at zero in IDLE so WARMUP always starts from a
            // full period, free-running while active, frozen in FAIL.
            if (state == S_IDLE) begin
                div_cnt <= '0;
            end else if (active) begin
                div_cnt <= strobe ? '0 : div_cnt + 1'b1;
            end

            if (state == S_IDLE) begin
                wu_cnt <= '0;
            end else if ((state == S_WARMUP) && strobe && !rep_hit) begin
                wu_cnt <= wu_cnt + 1'b1;
            end

            // Health history is forgotten whenever we sit in IDLE, which is
            // where every disable lands.
            if (state == S_IDLE) begin
                rep_cnt     <= 4'd0;
                prev_sample <= 8'd0;
            end else if (strobe) begin
                rep_cnt     <= rep_next;
                prev_sample <= rnddata;
            end

            // Byte index only advances while packing; any other state
            // restarts the next word at byte 0.
            if (state != S_COLLECT) begin
                byte_idx <= 2'd0;
            end else if (pack_write) begin
                byte_idx <= byte_idx + 2'd1;
            end

            if (pack_write) begin
                out_data[{byte_idx, 3'b000} +: 8] <= rnddata;
            end
        end
    end

endmodule

// File: tb/tb_trng_sched.sv
// tb/tb_trng_sched.sv - directed self-checking bench for trng_sched

module tb_trng_sched;

    logic        clk;
    logic        rst;
    logic        en;
    logic [7:0]  rnddata;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        health_fail;
    logic        busy;

    int n_total;
    int n_bad;

    trng_sched #(
        .SAMPLE_DIV    (4),
        .WARMUP_SAMPLES(2),
        .REP_LIMIT     (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rnddata    (rnddata),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .health_fail(health_fail),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then park on the falling edge to sample/drive.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Reset, then raise en; returns on the falling edge after the
    // IDLE->WARMUP edge (E1). Strobes then take effect at E5, E9, E13, ...
    task automatic start();
        rst = 1'b1;
        en  = 1'b0;
        rnddata = 8'h00;
        tick(1);
        rst = 1'b0;
        en  = 1'b1;
        tick(1);
    endtask

    // Hold one byte for exactly one sample period (one strobe).
    task automatic feed(input logic [7:0] b);
        rnddata = b;
        tick(4);
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst       = 1'b1;
        en        = 1'b0;
        rnddata   = 8'h00;
        out_ready = 1'b0;

        // Reset state
        tick(2);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_hfail", 32'(health_fail), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Normal flow: 11,22 discarded; word 0x66554433 valid for one cycle,
        // first visible after the 25th edge counted from the one sampling en.
        out_ready = 1'b1;
        start();
        check("warmup_busy", 32'(busy), 32'd1);
        feed(8'h11);
        feed(8'h22);
        feed(8'h33);
        feed(8'h44);
        feed(8'h55);
        check("norm_not_yet", 32'(out_valid), 32'd0);
        rnddata = 8'h66;
        tick(3);
        check("norm_pre_valid", 32'(out_valid), 32'd0);
        tick(1);
        check("norm_valid", 32'(out_valid), 32'd1);
        check("norm_data", out_data, 32'h66554433);
        tick(1);
        check("norm_pulse_end", 32'(out_valid), 32'd0);
        check("norm_data_hold", out_data, 32'h66554433);

        // Backpressure: 20-cycle stall in PRESENT, 5 strobes not packed
        out_ready = 1'b0;
        start();
        feed(8'h01);
        feed(8'h02);
        feed(8'ha1);
        feed(8'ha2);
        feed(8'ha3);
        feed(8'ha4);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_data", out_data, 32'ha4a3a2a1);
        feed(8'hb1);
        feed(8'hb2);
        check("bp_mid_valid", 32'(out_valid), 32'd1);
        feed(8'hb3);
        feed(8'hb4);
        feed(8'hb5);
        check("bp_stall_valid", 32'(out_valid), 32'd1);
        check("bp_stall_data", out_data, 32'ha4a3a2a1);
        out_ready = 1'b1;
        rnddata   = 8'hc1;
        tick(1);
        check("bp_hs_drop", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        tick(3);
        feed(8'hc2);
        feed(8'hc3);
        feed(8'hc4);
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_data", out_data, 32'hc4c3c2c1);

        // Repetition: constant 0xA5 fails on the third strobe
        out_ready = 1'b1;
        start();
        feed(8'ha5);
        feed(8'ha5);
        tick(3);
        check("rep_pre_fail", 32'(health_fail), 32'd0);
        tick(1);
        check("rep_fail", 32'(health_fail), 32'd1);
        check("rep_busy", 32'(busy), 32'd0);
        check("rep_valid", 32'(out_valid), 32'd0);
        en = 1'b0;
        tick(2);
        en = 1'b1;
        tick(8);
        check("rep_en_sticky", 32'(health_fail), 32'd1);
        check("rep_en_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        en  = 1'b0;
        check("rep_rst_clear", 32'(health_fail), 32'd0);

        // Disable mid-word, then re-enable with a full warmup
        out_ready = 1'b0;
        start();
        feed(8'h01);
        feed(8'h02);
        feed(8'hd1);
        feed(8'hd2);
        en = 1'b0;
        tick(1);
        check("dis_busy", 32'(busy), 32'd0);
        check("dis_valid", 32'(out_valid), 32'd0);
        check("dis_data_hold", out_data, 32'h0000d2d1);
        en = 1'b1;
        tick(1);
        feed(8'h03);
        feed(8'h04);
        feed(8'he1);
        feed(8'he2);
        feed(8'he3);
        check("dis_not_yet", 32'(out_valid), 32'd0);
        feed(8'he4);
        check("dis_valid2", 32'(out_valid), 32'd1);
        check("dis_data2", out_data, 32'he4e3e2e1);

        // Reset while presenting
        out_ready = 1'b0;
        start();
        feed(8'h01);
        feed(8'h02);
        feed(8'hf1);
        feed(8'hf2);
        feed(8'hf3);
        feed(8'hf4);
        check("rstp_valid_before", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick(1);
        check("rstp_valid", 32'(out_valid), 32'd0);
        check("rstp_data", out_data, 32'd0);
        check("rstp_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        en  = 1'b0;

        // Failure beats a handshake in the same cycle
        out_ready = 1'b0;
        start();
        feed(8'h01);
        feed(8'h02);
        feed(8'h31);
        feed(8'h32);
        feed(8'h77);
        feed(8'h77);
        check("fvh_present", 32'(out_valid), 32'd1);
        tick(3);
        check("fvh_pre", 32'(health_fail), 32'd0);
        out_ready = 1'b1;
        tick(1);
        check("fvh_fail", 32'(health_fail), 32'd1);
        check("fvh_valid", 32'(out_valid), 32'd0);
        check("fvh_busy", 32'(busy), 32'd0);
        check("fvh_data", out_data, 32'h77773231);
        tick(8);
        check("fvh_no_word", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
